// File: rtl/param_register_bank.sv
// Parametrised configuration register bank: ID ROM, control word, masked R/W config registers and a live status window.
// Define PARAM_REGBANK_SHADOW_COMMIT_EN to stage config writes in a shadow array that goes live on a CONTROL commit.
module param_register_bank #(
    parameter int                         ADDR_W        = 18,
    parameter int                         DATA_W        = 32,
    parameter int                         NUM_REGS      = 16,
    parameter int                         NUM_STATUS    = 4,
    parameter logic [ADDR_W-1:0]          BASE_ADDR     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] WR_MASK       = '1,
    parameter logic [31:0]                ID0           = 32'h43524F4D,
    parameter logic [31:0]                ID1           = 32'h00080030,
    parameter logic [31:0]                ID2           = 32'h00030904,
    parameter logic [31:0]                ID3           = 32'h00000000,
    parameter logic [31:0]                DUMMY_VALUE   = 32'hDEADBEEF,
    parameter int                         RST_PULSE_LEN = 16
) (
    input  logic                                                 CLK,
    input  logic                                                 RSTb,
    input  logic [ADDR_W-1:0]                                    ADDR,
    input  logic [DATA_W-1:0]                                    DATA_IN,
    output logic [DATA_W-1:0]                                    DATA_OUT,
    input  logic                                                 CEb,
    input  logic                                                 WEb,
    input  logic                                                 REb,
    output logic                                                 RD_VALID,
    output logic                                                 WR_ACK,
    input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*DATA_W-1:0] STATUS_IN,
    output logic [NUM_REGS*DATA_W-1:0]                           CFG_OUT,
    output logic [NUM_REGS-1:0]                                  WR_STROBE,
    output logic                                                 USER_RESET,
    output logic                                                 COMMIT_PENDING
);

    localparam int CTRL_OFF = 4;
    localparam int REG_LO   = 8;
    localparam int STAT_LO  = REG_LO + NUM_REGS;
    localparam int WIN      = STAT_LO + NUM_STATUS;
    localparam int CNT_W    = $clog2(RST_PULSE_LEN + 1);

    logic [ADDR_W-1:0]                offset;
    logic                             in_window;
    logic                             wr_now;
    logic                             rd_now;
    logic                             wr_accept;
    logic                             ctrl_wr;
    logic                             user_rst_req;
    logic [NUM_REGS-1:0]              reg_wr;
    logic [NUM_REGS-1:0][DATA_W-1:0]  wr_word;
    logic [NUM_REGS-1:0][DATA_W-1:0]  rd_src;
    logic [DATA_W-1:0]                rd_data;

    logic                             wr_prev_q,   wr_prev_d;
    logic                             rd_valid_q,  rd_valid_d;
    logic                             wr_ack_q,    wr_ack_d;
    logic [DATA_W-1:0]                data_out_q,  data_out_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  cfg_q,       cfg_d;
    logic [NUM_REGS-1:0]              wr_strobe_q, wr_strobe_d;
    logic [CNT_W-1:0]                 rst_cnt_q,   rst_cnt_d;

`ifdef PARAM_REGBANK_SHADOW_COMMIT_EN
    logic                             commit_req;
    logic [NUM_REGS-1:0][DATA_W-1:0]  shadow_q,    shadow_d;
    logic [NUM_REGS-1:0]              dirty_q,     dirty_d;
`endif

    // Address decode; the subtraction wraps so addresses below BASE_ADDR land outside the window.
    always_comb begin
        offset       = ADDR - BASE_ADDR;
        in_window    = (offset < ADDR_W'(WIN));
        wr_now       = !CEb && !WEb;
        rd_now       = !CEb && !REb && in_window;
        wr_accept    = wr_now && !wr_prev_q && in_window;
        ctrl_wr      = wr_accept && (offset == ADDR_W'(CTRL_OFF));
        user_rst_req = ctrl_wr && DATA_IN[0];
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_wr[k]  = wr_accept && (offset == ADDR_W'(REG_LO + k));
            wr_word[k] = DATA_IN & WR_MASK[k*DATA_W +: DATA_W];
        end
    end

`ifdef PARAM_REGBANK_SHADOW_COMMIT_EN
    assign commit_req = ctrl_wr && DATA_IN[1];
    assign rd_src     = shadow_q;
`else
    assign rd_src     = cfg_q;
`endif

    // NOTE: every variable in a combinational block gets a default first, otherwise unassigned paths infer latches.
    always_comb begin
        rd_data = '0;
        if (offset < ADDR_W'(CTRL_OFF)) begin
            case (offset[1:0])
                2'd0:    rd_data = ID0[DATA_W-1:0];
                2'd1:    rd_data = ID1[DATA_W-1:0];
                2'd2:    rd_data = ID2[DATA_W-1:0];
                default: rd_data = ID3[DATA_W-1:0];
            endcase
        end else if (offset == ADDR_W'(CTRL_OFF)) begin
            rd_data = '0;
        end else if (offset < ADDR_W'(REG_LO)) begin
            rd_data = DUMMY_VALUE[DATA_W-1:0];
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (offset == ADDR_W'(REG_LO + k)) begin
                    rd_data = rd_src[k];
                end
            end
            for (int s = 0; s < NUM_STATUS; s++) begin
                if (offset == ADDR_W'(STAT_LO + s)) begin
                    rd_data = STATUS_IN[s*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read data comes from the current register state, so a same-cycle write is seen only by the next read.
    always_comb begin
        wr_prev_d  = wr_now;
        rd_valid_d = rd_now;
        wr_ack_d   = wr_accept;
        data_out_d = rd_now ? rd_data : data_out_q;
    end

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (user_rst_req) begin
            rst_cnt_d = CNT_W'(RST_PULSE_LEN);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
        end
    end

`ifdef PARAM_REGBANK_SHADOW_COMMIT_EN
    // Commit copies the pre-write shadow, so a config write coinciding with it stays staged.
    always_comb begin
        cfg_d       = cfg_q;
        shadow_d    = shadow_q;
        dirty_d     = dirty_q;
        wr_strobe_d = '0;
        if (commit_req) begin
            cfg_d       = shadow_q;
            wr_strobe_d = dirty_q;
            dirty_d     = '0;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reg_wr[k]) begin
                shadow_d[k] = wr_word[k];
                dirty_d[k]  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        cfg_d       = cfg_q;
        wr_strobe_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reg_wr[k]) begin
                cfg_d[k]       = wr_word[k];
                wr_strobe_d[k] = 1'b1;
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            wr_prev_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            data_out_q  <= '0;
            wr_strobe_q <= '0;
            rst_cnt_q   <= '0;
        end else begin
            wr_prev_q   <= wr_prev_d;
            rd_valid_q  <= rd_valid_d;
            wr_ack_q    <= wr_ack_d;
            data_out_q  <= data_out_d;
            wr_strobe_q <= wr_strobe_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    // NOTE: the register array is reset because downstream logic acts on CFG_OUT straight out of reset.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

`ifdef PARAM_REGBANK_SHADOW_COMMIT_EN
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            shadow_q <= '0;
            dirty_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end

    assign COMMIT_PENDING = |dirty_q;
`else
    assign COMMIT_PENDING = 1'b0;
`endif

    assign DATA_OUT   = data_out_q;
    assign RD_VALID   = rd_valid_q;
    assign WR_ACK     = wr_ack_q;
    assign CFG_OUT    = cfg_q;
    assign WR_STROBE  = wr_strobe_q;
    assign USER_RESET = (rst_cnt_q != '0);

endmodule

// File: doc/param_register_bank.md
Name: param_register_bank

Overview:
- Parametrised successor to the board configuration register bank.
- Holds NUM_REGS generic read/write configuration words of DATA_W bits, a read-only status window of NUM_STATUS words and a 4-word identification ROM.
- Adds per-register write masks, one-shot write strobes, edge-qualified writes, a read-valid handshake and a stretched self-clearing user reset.
- Sits between the local bus decoder and the acquisition/trigger logic; consumers take the flattened CFG_OUT bus.

Parameters:
- ADDR_W, 18, bus address width.
- DATA_W, 32, register width (8..32).
- NUM_REGS, 16, number of R/W configuration registers (1..64).
- NUM_STATUS, 4, number of read-only status words (0..16).
- BASE_ADDR, 0, address of offset 0; the block decodes BASE_ADDR .. BASE_ADDR+8+NUM_REGS+NUM_STATUS-1.
- WR_MASK, all ones, flattened NUM_REGS*DATA_W mask; 0 bits are read-only and forced to 0.
- ID0..ID3, 32'h43524F4D / 32'h00080030 / 32'h00030904 / 32'h0, ROM words.
- DUMMY_VALUE, 32'hDEADBEEF, read data for an unmapped in-window offset.
- RST_PULSE_LEN, 16, USER_RESET length in clocks (>=1).

Ports:
- CLK  in  1  system clock.
- RSTb  in  1  asynchronous active-low reset.
- ADDR  in  ADDR_W  bus address.
- DATA_IN  in  DATA_W  write data.
- DATA_OUT  out  DATA_W  registered read data.
- CEb, WEb, REb  in  1  active-low chip, write and read enables.
- RD_VALID  out  1  read data valid pulse.
- WR_ACK  out  1  write accepted pulse.
- STATUS_IN  in  NUM_STATUS*DATA_W  read-only status words.
- CFG_OUT  out  NUM_REGS*DATA_W  configuration registers, reg k at [k*DATA_W +: DATA_W].
- WR_STROBE  out  NUM_REGS  one-cycle pulse per register written.
- USER_RESET  out  1  stretched soft reset.
- COMMIT_PENDING  out  1  shadow differs from live (optional feature only; otherwise tied 0).

Behaviour:
- Reset: CLK single clock domain. RSTb asynchronous active-low. Reset asserted gives all CFG_OUT = 0, DATA_OUT = 0, RD_VALID = 0, WR_ACK = 0, WR_STROBE = 0, USER_RESET = 0, COMMIT_PENDING = 0, pulse counter = 0, edge registers = 0. Reset mid-pulse aborts USER_RESET immediately.
- Offset map (ADDR - BASE_ADDR):
  - 0..3: ROM ID0..ID3, zero-extended or truncated to DATA_W.
  - 4: CONTROL, write-only. bit0 = user reset, bit1 = commit. Reads return 0.
  - 5..7: reserved. Reads return DUMMY_VALUE; writes are ignored.
  - 8 .. 8+NUM_REGS-1: config regs.
  - Next NUM_STATUS offsets: STATUS_IN words.
  - Outside the window: no response, no RD_VALID, no WR_ACK.
- Write acceptance: wr_now = !CEb & !WEb.
  - A write is accepted only on the rising edge of wr_now (previous cycle wr_now = 0), so a held WEb writes once.
  - Config reg k <= (DATA_IN & mask_k), registered at that clock.
  - WR_STROBE[k] and WR_ACK pulse high exactly 1 cycle later.
  - WR_ACK also pulses for in-window writes to ROM, reserved or status offsets, which are ignored.
- Read: rd_now = !CEb & !REb, in window.
  - DATA_OUT is updated at the next clock and RD_VALID pulses in that same cycle; latency 1.
  - A held REb re-samples every cycle and keeps RD_VALID high; status is live.
  - Simultaneous read and write of the same reg returns the old value.
- USER_RESET:
  - An accepted CONTROL write with bit0 = 1 loads the counter with RST_PULSE_LEN.
  - USER_RESET is high while counter != 0; the counter decrements each cycle.
  - A re-write during a pulse restarts the full length.
  - USER_RESET does not clear config regs.
- Widths: mask bits are applied on write. Reads are zero-padded to DATA_W. ADDR - BASE_ADDR is computed unsigned in ADDR_W bits, so addresses below BASE_ADDR wrap and fall outside the window.

Optional Feature:
- Macro: PARAM_REGBANK_SHADOW_COMMIT_EN.
- Defined:
  - Writes to config offsets go to a shadow array. Reads of config offsets return the shadow.
  - CFG_OUT and WR_STROBE are unchanged by the write itself.
  - COMMIT_PENDING goes high the cycle after any shadow write.
  - A CONTROL write with bit1 = 1 copies all shadow regs to live in one clock. WR_STROBE pulses for every reg written since the last commit, and COMMIT_PENDING clears the following cycle.
  - Commit and user reset in the same write both take effect.
  - A write to a config offset in the same cycle as a commit lands in the shadow only.
- Undefined: no shadow. Writes update CFG_OUT directly as above, bit1 of CONTROL is ignored, COMMIT_PENDING is 0.

Test Plan:
- Reset, then read offsets 0..3 -> 43524F4D, 00080030, 00030904, 00000000 with RD_VALID 1 cycle after REb low. Read offset 6 -> DEADBEEF.
- WR_MASK reg2 = 0000FFFF; write reg2 = 12345678 -> CFG_OUT reg2 = 00005678, WR_STROBE[2] high for exactly 1 cycle, readback 00005678.
- Hold CEb/WEb low for 5 cycles writing reg0 = A5 -> a single WR_STROBE[0] pulse and a single WR_ACK.
- Write CONTROL = 1 with RST_PULSE_LEN = 16 -> USER_RESET high 16 cycles. Re-write at cycle 10 -> USER_RESET high 26 cycles total. RSTb low at cycle 5 -> USER_RESET 0 immediately.
- STATUS_IN word0 = CAFE0001, REb held low while STATUS_IN changes to CAFE0002 -> DATA_OUT tracks with 1-cycle lag. Writes to the status offset -> WR_ACK only, no change.
- With the shadow feature: write reg1 = 11, reg3 = 33 -> CFG_OUT unchanged, COMMIT_PENDING = 1. CONTROL = 2 -> both regs live on the same clock, WR_STROBE = 0x000A, COMMIT_PENDING = 0.
